// File: rtl/auction_stream_tracker.sv
// rtl/auction_stream_tracker.sv - second-price auction stage over a bid stream
// Tracks best/second bids per round and holds the result until accepted.
module auction_stream_tracker #(
  parameter int W     = 16,
  parameter int N_MAX = 16,
  parameter int IDXW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bid_valid,
  output logic            bid_ready,
  input  logic [W-1:0]    bid_value,
  input  logic            bid_last,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [IDXW-1:0] res_winner,
  output logic [W-1:0]    res_price,
  output logic            res_nobid,
  output logic [IDXW:0]   res_count
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t          state;
  logic [IDXW:0]   count;
  logic [W-1:0]    best;
  logic [W-1:0]    second;
  logic [IDXW-1:0] best_idx;
  logic            anyz;

  logic            xfer;
  logic            beats_best;
  logic            beats_second;
  logic [W-1:0]    n_best;
  logic [W-1:0]    n_second;
  logic [IDXW-1:0] n_idx;
  logic [IDXW:0]   n_count;
  logic            n_anyz;
  logic            close;

  // Post-update view of the round, shared by the accumulators and the result load
  always_comb begin
    xfer         = bid_valid & bid_ready;
    beats_best   = bid_value > best;
    beats_second = bid_value > second;
    n_best       = beats_best ? bid_value : best;
    n_idx        = beats_best ? count[IDXW-1:0] : best_idx;
    n_second     = beats_best ? best : (beats_second ? bid_value : second);
    n_count      = count + 1'b1;
    n_anyz       = anyz | (bid_value != '0);
    close        = bid_last | (n_count == (IDXW+1)'(N_MAX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      count      <= '0;
      best       <= '0;
      second     <= '0;
      best_idx   <= '0;
      anyz       <= 1'b0;
      bid_ready  <= 1'b1;
      res_valid  <= 1'b0;
      res_winner <= '0;
      res_price  <= '0;
      res_nobid  <= 1'b0;
      res_count  <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (xfer) begin
            if (close) begin
              res_winner <= n_idx;
              res_price  <= (n_count >= (IDXW+1)'(2)) ? n_second : '0;
              res_nobid  <= ~n_anyz;
              res_count  <= n_count;
              res_valid  <= 1'b1;
              bid_ready  <= 1'b0;
              state      <= HOLD;
              count      <= '0;
              best       <= '0;
              second     <= '0;
              best_idx   <= '0;
              anyz       <= 1'b0;
            end else begin
              count    <= n_count;
              best     <= n_best;
              second   <= n_second;
              best_idx <= n_idx;
              anyz     <= n_anyz;
            end
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            bid_ready <= 1'b1;
            state     <= COLLECT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_auction_stream_tracker.sv
// tb/tb_auction_stream_tracker.sv - directed and random checks against a round-level model
module tb_auction_stream_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        bid_valid;
  logic        bid_ready;
  logic [15:0] bid_value;
  logic        bid_last;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_winner;
  logic [15:0] res_price;
  logic        res_nobid;
  logic [4:0]  res_count;

  int errors = 0;
  int checks = 0;
  int unsigned q[$];
  int unsigned exp_winner, exp_price, exp_nobid, exp_count;

  auction_stream_tracker #(.W(16), .N_MAX(16), .IDXW(4)) dut (
    .clk(clk), .rst(rst),
    .bid_valid(bid_valid), .bid_ready(bid_ready), .bid_value(bid_value), .bid_last(bid_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_winner(res_winner),
    .res_price(res_price), .res_nobid(res_nobid), .res_count(res_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
  endtask

  task automatic push(input int unsigned v, input logic last, input int gap);
    int n;
    bid_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bid_valid = 1'b1;
    bid_value = v[15:0];
    bid_last  = last;
    n = 0;
    @(negedge clk);
    while (!bid_ready && n < 50) begin @(negedge clk); n++; end
    chk("bid_ready_at_push", bid_ready, 1);
    @(posedge clk);
    #1 bid_valid = 1'b0;
    bid_last = 1'b0;
    q.push_back(v);
  endtask

  // Winner = first occurrence of the maximum; price = second element of the bids sorted high-to-low
  task automatic model();
    int unsigned s[$];
    exp_winner = 0;
    for (int i = 0; i < q.size(); i++)
      if (q[i] > q[exp_winner]) exp_winner = i;
    s = q;
    s.rsort();
    exp_price = (q.size() >= 2) ? s[1] : 0;
    exp_nobid = (s[0] == 0) ? 1 : 0;
    exp_count = q.size();
  endtask

  task automatic check_round(input string tag);
    model();
    chk({tag, "_valid"},  res_valid, 1);
    chk({tag, "_ready0"}, bid_ready, 0);
    chk({tag, "_winner"}, res_winner, exp_winner);
    chk({tag, "_price"},  res_price, exp_price);
    chk({tag, "_nobid"},  res_nobid, exp_nobid);
    chk({tag, "_count"},  res_count, exp_count);
    q.delete();
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    chk({tag, "_valid_fall"}, res_valid, 0);
    chk({tag, "_ready_rise"}, bid_ready, 1);
  endtask

  initial begin
    int len, mode;
    int unsigned v;
    logic last;
    bid_valid = 1'b0;
    bid_value = '0;
    bid_last  = 1'b0;
    res_ready = 1'b0;
    do_reset();

    @(negedge clk);
    chk("rst_valid", res_valid, 0);
    chk("rst_ready", bid_ready, 1);
    chk("rst_winner", res_winner, 0);
    chk("rst_price", res_price, 0);
    chk("rst_nobid", res_nobid, 0);
    chk("rst_count", res_count, 0);
    @(posedge clk); #1;

    push(10, 0, 0); push(30, 0, 0);
    chk("mid_round_no_valid", res_valid, 0);
    push(20, 1, 0);
    check_round("r_10_30_20");
    consume("r_10_30_20");

    push(7, 1, 0);
    check_round("r_single");
    consume("r_single");

    push(0, 0, 0); push(0, 1, 0);
    check_round("r_zeros");
    consume("r_zeros");

    push(9, 0, 0); push(9, 0, 0); push(4, 1, 0);
    check_round("r_tie_994");
    consume("r_tie_994");

    push(3, 0, 1); push(9, 0, 0); push(9, 1, 2);
    check_round("r_tie_399");
    consume("r_tie_399");

    for (int i = 0; i < 16; i++) push(i, 0, 0);
    check_round("r_forced");
    consume("r_forced");

    push(5, 0, 0); push(6, 1, 0);
    model();
    for (int c = 0; c < 5; c++) begin
      bid_valid = 1'b1;
      bid_value = 16'($urandom);
      bid_last  = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid", res_valid, 1);
      chk("bp_ready", bid_ready, 0);
      chk("bp_winner", res_winner, exp_winner);
      chk("bp_count", res_count, exp_count);
    end
    check_round("r_backpressure");
    consume("r_backpressure");
    bid_valid = 1'b0;
    bid_last  = 1'b0;

    push(40, 0, 0); push(50, 0, 0);
    do_reset();
    chk("abort_valid", res_valid, 0);
    chk("abort_ready", bid_ready, 1);
    chk("abort_count", res_count, 0);
    push(1, 0, 0); push(2, 1, 0);
    check_round("r_after_abort");
    consume("r_after_abort");

    for (int r = 0; r < 24; r++) begin
      len  = $urandom_range(1, 16);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < len; i++) begin
        v = (mode == 0) ? $urandom_range(0, 3) : ((mode == 1) ? 0 : ($urandom & 32'hFFFF));
        if (mode == 1 && $urandom_range(0, 3) == 0) v = $urandom_range(1, 2);
        last = (i == len - 1);
        if (len == 16 && i == 15) last = $urandom_range(0, 1) != 0;
        push(v, last, $urandom_range(0, 2));
      end
      check_round("r_random");
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      consume("r_random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
